// File: rtl/div32u_if.sv
`default_nettype none
// ============================================================================
// Module   : div32u_if
// Purpose  : Start/operand/result bundle for div32u_seq (dz exists only with
//            DIV32U_DIVZERO_EN).
// Revision : 1.0 - initial release
// ============================================================================
interface div32u_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;
`ifdef DIV32U_DIVZERO_EN
  logic               dz;

  modport master (output start, op1, op2, input busy, done, res, dz);
  modport slave  (input start, op1, op2, output busy, done, res, dz);
`else
  modport master (output start, op1, op2, input busy, done, res);
  modport slave  (input start, op1, op2, output busy, done, res);
`endif
endinterface
`default_nettype wire

// File: rtl/div32u_seq.sv
`default_nettype none
// ============================================================================
// Module   : div32u_seq
// Purpose  : Restoring radix-2 unsigned divider, one quotient bit per clock.
//            Optional divide-by-zero shortcut via DIV32U_DIVZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div32u_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div32u_if.slave  bus
);

  localparam int         c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [2*WIDTH-1:0] r_res;

  logic               w_accept;
  logic               w_last;
  logic               w_zero;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_q_nxt;

  assign w_accept = bus.start && (r_state != c_RUN);
  assign w_last   = (r_cnt == c_CNT_W'(1));

`ifdef DIV32U_DIVZERO_EN
  logic r_dz;
  assign w_zero = (bus.op2 == '0);
  assign bus.dz = r_dz;
`else
  assign w_zero = 1'b0;
`endif

  // The full WIDTH+1 bit compare keeps the shifted-out remainder MSB; the
  // subtraction result itself always fits in WIDTH bits.
  assign w_shift   = {r_rem, r_q[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_shift[WIDTH-1:0] - (w_ge ? r_dvs : '0);
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) w_next = w_zero ? c_DONE : c_RUN;
      end
      c_RUN: begin
        if (w_last) w_next = c_DONE;
      end
      c_DONE: begin
        if (w_accept) w_next = w_zero ? c_DONE : c_RUN;
        else          w_next = c_IDLE;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == c_RUN);
    bus.done = (r_state == c_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_res <= '0;
`ifdef DIV32U_DIVZERO_EN
      r_dz  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_q   <= bus.op1;
      r_dvs <= bus.op2;
      r_rem <= '0;
      r_cnt <= c_CNT_W'(WIDTH);
`ifdef DIV32U_DIVZERO_EN
      r_dz  <= w_zero;
      if (w_zero) r_res <= {bus.op1, {WIDTH{1'b1}}};
`endif
    end else if (r_state == c_RUN) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (w_last) r_res <= {w_rem_nxt, w_q_nxt};
    end
  end

  assign bus.res = r_res;

endmodule
`default_nettype wire

// File: tb/tb_div32u_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div32u_seq
// Purpose  : Scoreboard bench for div32u_seq against a plain / and % model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div32u_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div32u_if #(.WIDTH(W)) bus ();
  div32u_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int unsigned    when;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

`ifdef DIV32U_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result pending", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("res", bus.res, e.res);
        check("latency", 64'(cyc), 64'(e.when));
`ifdef DIV32U_DIVZERO_EN
        check("dz", 64'(bus.dz), 64'(e.dz));
`endif
      end
    end
  end

  // Drive a start; when 'now' is set the caller is already at the wanted negedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = a;
    bus.op2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op1   = $urandom;
    bus.op2   = $urandom;
    e.res  = ref_div(a, b);
    e.dz   = DZ_EN && (b == '0);
    e.when = cyc + ((DZ_EN && b == '0) ? 1 : W);
    sbq.push_back(e);
    if (!(DZ_EN && b == '0)) check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d results pending expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
  endtask

  task automatic wait_done_negedge(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_res"},  bus.res, '0);
`ifdef DIV32U_DIVZERO_EN
    check({tag, "_dz"},   64'(bus.dz), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    bus.start = 1'b0;
    bus.op1   = '0;
    bus.op2   = '0;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    issue(32'd100, 32'd7, 1'b0);
    wait_idle(60);

    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_idle(60);
    issue(32'd5, 32'h8000_0000, 1'b0);
    wait_idle(60);

    // Start during busy must be ignored; then back-to-back start in the done cycle.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = 32'd9;
    bus.op2   = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done_negedge(60);
    issue(32'd9, 32'd9, 1'b1);
    wait_idle(60);

    // Asynchronous reset mid-division.
    issue(32'd100, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd50, 32'd8, 1'b0);
    wait_idle(60);

    issue(32'd123, 32'd0, 1'b0);
    wait_idle(60);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = '0;
        2:       b = 32'd1;
        3:       b = a + 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 2) == 0 && sbq.size() != 0) begin
        wait_done_negedge(60);
        issue(a, b, 1'b1);
      end else begin
        wait_idle(60);
        issue(a, b, 1'b0);
      end
    end
    wait_idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
